varint_out_rr_fsm: RTL and testbench



---
 rtl/varint_out_pkg.sv | 15 +
 rtl/varint_rr_pick.sv | 34 +++
 rtl/varint_out_rr_fsm.sv | 132 +++++++++++++
 tb/tb_varint_out_rr_fsm.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/varint_out_pkg.sv
// Shared state encoding and sizing helper for the multi-channel varint output controller.
package varint_out_pkg;

    typedef enum logic [2:0] {
        INIT    = 3'b001,
        V_FETCH = 3'b010,
        V_READY = 3'b100
    } state_t;

    // Channel index width, never narrower than one bit so NUM_CH=1 still has a port.
    function automatic int unsigned ch_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/varint_rr_pick.sv
// Combinational round-robin picker: first requesting channel at or after i_ptr, cyclic.
module varint_rr_pick #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CH_W   = 2
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [CH_W-1:0]   i_ptr,
    output logic [CH_W-1:0]   o_grant,
    output logic [NUM_CH-1:0] o_grant_oh,
    output logic              o_any
);

    int unsigned w_idx;

    // Scan from the farthest offset down so the nearest requester wins.
    always_comb begin
        o_grant    = '0;
        o_grant_oh = '0;
        w_idx      = 0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            w_idx = 32'(i_ptr) + 32'(k);
            if (w_idx >= NUM_CH) begin
                w_idx = w_idx - NUM_CH;
            end
            if (|(i_req & (NUM_CH'(1) << w_idx))) begin
                o_grant    = CH_W'(w_idx);
                o_grant_oh = NUM_CH'(1) << w_idx;
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/varint_out_rr_fsm.sv
// Round-robin drain of NUM_CH varint data/index FIFO pairs into one registered valid/accepted output.
module varint_out_rr_fsm
    import varint_out_pkg::*;
#(
    parameter  int unsigned NUM_CH       = 4,
    parameter  int unsigned DATA_W       = 64,
    parameter  int unsigned IDX_W        = 8,
    parameter  int unsigned CNT_W        = 32,
    parameter  int unsigned BACK_TO_BACK = 1,
    localparam int unsigned CH_W         = ch_width(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        varint_out_fifo_empty,
    input  logic [NUM_CH*DATA_W-1:0] varint_out_fifo_data,
    input  logic [NUM_CH*IDX_W-1:0]  varint_out_index_data,
    output logic [NUM_CH-1:0]        varint_out_fifo_pop,
    output logic [NUM_CH-1:0]        varint_out_index_pop,
    input  logic                     varint_data_accepted,
    output logic                     varint_data_valid,
    output logic [DATA_W-1:0]        varint_data,
    output logic [IDX_W-1:0]         varint_index,
    output logic [CH_W-1:0]          varint_channel,
    output logic [CNT_W-1:0]         accepted_count
);

    state_t              r_state;
    logic [CH_W-1:0]     r_rr_ptr;
    logic                r_valid;
    logic [DATA_W-1:0]   r_data;
    logic [IDX_W-1:0]    r_index;
    logic [CH_W-1:0]     r_channel;
    logic [CNT_W-1:0]    r_count;

    logic [CH_W-1:0]     w_grant;
    logic [NUM_CH-1:0]   w_grant_oh;
    logic                w_any;
    logic                w_fetch;
    logic [CH_W-1:0]     w_next_ptr;
    logic [DATA_W-1:0]   w_head_data;
    logic [IDX_W-1:0]    w_head_idx;

    varint_rr_pick #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_pick (
        .i_req      (~varint_out_fifo_empty),
        .i_ptr      (r_rr_ptr),
        .o_grant    (w_grant),
        .o_grant_oh (w_grant_oh),
        .o_any      (w_any)
    );

    // A fetch happens in V_FETCH, or in V_READY on accept when back-to-back is enabled.
    always_comb begin
        w_fetch = 1'b0;
        if (!reset && w_any) begin
            case (r_state)
                V_FETCH: w_fetch = 1'b1;
                V_READY: w_fetch = varint_data_accepted && (BACK_TO_BACK != 0);
                default: w_fetch = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_head_data = '0;
        w_head_idx  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_grant_oh[c]) begin
                w_head_data = w_head_data | varint_out_fifo_data[c*DATA_W +: DATA_W];
                w_head_idx  = w_head_idx  | varint_out_index_data[c*IDX_W +: IDX_W];
            end
        end
    end

    assign w_next_ptr = (32'(w_grant) == NUM_CH - 1) ? '0 : w_grant + CH_W'(1);

    assign varint_out_fifo_pop  = w_fetch ? w_grant_oh : '0;
    assign varint_out_index_pop = varint_out_fifo_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= INIT;
            r_rr_ptr  <= '0;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_index   <= '0;
            r_channel <= '0;
            r_count   <= '0;
        end else begin
            if (r_valid && varint_data_accepted) begin
                r_count <= r_count + CNT_W'(1);
            end
            if (w_fetch) begin
                r_data    <= w_head_data;
                r_index   <= w_head_idx;
                r_channel <= w_grant;
                r_rr_ptr  <= w_next_ptr;
            end
            case (r_state)
                INIT: begin
                    r_state <= V_FETCH;
                    r_valid <= 1'b0;
                end
                V_FETCH: begin
                    if (w_fetch) begin
                        r_state <= V_READY;
                        r_valid <= 1'b1;
                    end
                end
                V_READY: begin
                    if (varint_data_accepted && !w_fetch) begin
                        r_state <= V_FETCH;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= INIT;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign varint_data_valid = r_valid;
    assign varint_data       = r_data;
    assign varint_index      = r_index;
    assign varint_channel    = r_channel;
    assign accepted_count    = r_count;

endmodule

// File: tb/tb_varint_out_rr_fsm.sv
// Scoreboard bench: two instances (back-to-back on/off) fed from identical FIFO models.
module tb_varint_out_rr_fsm;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned IDX_W  = 8;
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned CH_W   = 2;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic [IDX_W-1:0]  i;
    } ent_t;

    typedef struct packed {
        logic [CH_W-1:0]   ch;
        logic [DATA_W-1:0] d;
        logic [IDX_W-1:0]  i;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic acc;
    always #5 clk = ~clk;

    logic [NUM_CH-1:0]        empty [2];
    logic [NUM_CH*DATA_W-1:0] fdata [2];
    logic [NUM_CH*IDX_W-1:0]  idata [2];
    logic [NUM_CH-1:0]        pop   [2];
    logic [NUM_CH-1:0]        ipop  [2];
    logic                     valid [2];
    logic [DATA_W-1:0]        data  [2];
    logic [IDX_W-1:0]         index [2];
    logic [CH_W-1:0]          chan  [2];
    logic [CNT_W-1:0]         cnt   [2];

    ent_t q [2][NUM_CH][$];
    exp_t expq [2][$];

    int checks = 0;
    int errors = 0;
    int mon_checks = 0;
    int mon_errors = 0;

    varint_out_rr_fsm #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .IDX_W(IDX_W), .CNT_W(CNT_W), .BACK_TO_BACK(1)
    ) dut_b2b (
        .clk(clk), .reset(reset),
        .varint_out_fifo_empty(empty[0]), .varint_out_fifo_data(fdata[0]),
        .varint_out_index_data(idata[0]), .varint_out_fifo_pop(pop[0]),
        .varint_out_index_pop(ipop[0]), .varint_data_accepted(acc),
        .varint_data_valid(valid[0]), .varint_data(data[0]), .varint_index(index[0]),
        .varint_channel(chan[0]), .accepted_count(cnt[0])
    );

    varint_out_rr_fsm #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .IDX_W(IDX_W), .CNT_W(CNT_W), .BACK_TO_BACK(0)
    ) dut_nb (
        .clk(clk), .reset(reset),
        .varint_out_fifo_empty(empty[1]), .varint_out_fifo_data(fdata[1]),
        .varint_out_index_data(idata[1]), .varint_out_fifo_pop(pop[1]),
        .varint_out_index_pop(ipop[1]), .varint_data_accepted(acc),
        .varint_data_valid(valid[1]), .varint_data(data[1]), .varint_index(index[1]),
        .varint_channel(chan[1]), .accepted_count(cnt[1])
    );

    // Monitor: pop legality every cycle, and word-by-word scoreboard on each accepted output.
    always @(negedge clk) begin
        for (int dd = 0; dd < 2; dd++) begin
            if (!reset) begin
                mon_checks++;
                if ($countones(pop[dd]) > 1 || (pop[dd] & empty[dd]) != '0 || ipop[dd] != pop[dd]) begin
                    mon_errors++;
                    $display("FAIL pop_legal dut%0d pop %b ipop %b empty %b", dd, pop[dd], ipop[dd], empty[dd]);
                end
                if (valid[dd] && acc) begin
                    mon_checks++;
                    if (expq[dd].size() == 0) begin
                        mon_errors++;
                        $display("FAIL word dut%0d unexpected ch %0d data %h idx %h", dd, chan[dd], data[dd], index[dd]);
                    end else begin
                        exp_t e;
                        e = expq[dd].pop_front();
                        if (chan[dd] !== e.ch || data[dd] !== e.d || index[dd] !== e.i) begin
                            mon_errors++;
                            $display("FAIL word dut%0d got ch %0d data %h idx %h expected ch %0d data %h idx %h",
                                     dd, chan[dd], data[dd], index[dd], e.ch, e.d, e.i);
                        end
                    end
                end
            end
        end
    end

    task automatic refresh();
        for (int dd = 0; dd < 2; dd++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                empty[dd][c] = (q[dd][c].size() == 0);
                if (q[dd][c].size() != 0) begin
                    fdata[dd][c*DATA_W +: DATA_W] = q[dd][c][0].d;
                    idata[dd][c*IDX_W +: IDX_W]   = q[dd][c][0].i;
                end else begin
                    fdata[dd][c*DATA_W +: DATA_W] = '0;
                    idata[dd][c*IDX_W +: IDX_W]   = '0;
                end
            end
        end
    endtask

    // Loads one FIFO entry into both models and records the word expected downstream.
    task automatic load(input int ch, input logic [DATA_W-1:0] d, input logic [IDX_W-1:0] i);
        ent_t en;
        exp_t ex;
        en.d = d; en.i = i;
        ex.ch = CH_W'(ch); ex.d = d; ex.i = i;
        for (int dd = 0; dd < 2; dd++) begin
            q[dd][ch].push_back(en);
            expq[dd].push_back(ex);
        end
        refresh();
    endtask

    function automatic logic [DATA_W-1:0] mk_d(input int ch, input int k);
        return 64'hC0DE_0000_0000_0000 | 64'(ch * 16 + k);
    endfunction

    function automatic logic [IDX_W-1:0] mk_i(input int ch, input int k);
        return 8'(ch * 16 + k);
    endfunction

    // One clock: latch settled pops, cross the edge, update FIFO models.
    task automatic step();
        logic [NUM_CH-1:0] ps [2];
        #1;
        ps[0] = pop[0];
        ps[1] = pop[1];
        @(posedge clk);
        #1;
        for (int dd = 0; dd < 2; dd++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ps[dd][c] && q[dd][c].size() != 0) begin
                    void'(q[dd][c].pop_front());
                end
            end
        end
        refresh();
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %h required %h", nm, act, req);
        end
    endtask

    logic [17:0] vh [2];
    logic [17:0] ph [2];
    logic [DATA_W-1:0] hd [2];
    logic [IDX_W-1:0]  hi [2];
    logic [CH_W-1:0]   hc [2];
    int ord1 [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    initial begin
        reset = 1'b1;
        acc   = 1'b0;
        refresh();
        repeat (3) step();

        for (int dd = 0; dd < 2; dd++) begin
            chk($sformatf("reset_valid%0d", dd), 64'(valid[dd]), 64'd0);
            chk($sformatf("reset_data%0d", dd), data[dd], 64'd0);
            chk($sformatf("reset_idx_ch%0d", dd), {index[dd], 6'd0, chan[dd]}, 64'd0);
            chk($sformatf("reset_cnt%0d", dd), 64'(cnt[dd]), 64'd0);
        end

        // Full round robin: every channel holds two entries, downstream always accepts.
        for (int n = 0; n < 8; n++) begin
            load(ord1[n], mk_d(ord1[n], n / 4), mk_i(ord1[n], n / 4));
        end
        acc   = 1'b1;
        reset = 1'b0;
        vh[0] = '0; vh[1] = '0; ph[0] = '0; ph[1] = '0;
        for (int k = 1; k <= 18; k++) begin
            step();
            for (int dd = 0; dd < 2; dd++) begin
                vh[dd][k-1] = valid[dd];
                ph[dd][k-1] = (pop[dd] != '0);
            end
        end
        chk("b2b_valid_pattern", 64'(vh[0]), 64'h001FE);
        chk("b2b_pop_pattern",   64'(ph[0]), 64'h000FF);
        chk("nb_valid_pattern",  64'(vh[1]), 64'h0AAAA);
        chk("nb_pop_pattern",    64'(ph[1]), 64'h05555);
        chk("b2b_count8", 64'(cnt[0]), 64'd8);
        chk("nb_count8",  64'(cnt[1]), 64'd8);

        // Move rr_ptr to 3 via one channel-2 grant, then only channel 2 has work.
        load(2, mk_d(2, 4), mk_i(2, 4));
        repeat (6) step();
        for (int k = 5; k < 8; k++) load(2, mk_d(2, k), mk_i(2, k));
        repeat (10) step();
        chk("b2b_count12", 64'(cnt[0]), 64'd12);
        chk("nb_count12",  64'(cnt[1]), 64'd12);

        // Downstream stalls while a word is held.
        acc = 1'b0;
        load(0, mk_d(0, 8), mk_i(0, 8));
        load(1, mk_d(1, 8), mk_i(1, 8));
        repeat (3) step();
        for (int dd = 0; dd < 2; dd++) begin
            chk($sformatf("hold_valid%0d", dd), 64'(valid[dd]), 64'd1);
            hd[dd] = data[dd]; hi[dd] = index[dd]; hc[dd] = chan[dd];
        end
        for (int k = 0; k < 5; k++) begin
            step();
            for (int dd = 0; dd < 2; dd++) begin
                chk($sformatf("hold_stable%0d_%0d", dd, k),
                    {data[dd][47:0], index[dd], 6'd0, chan[dd]},
                    {mk_d(0, 8)[47:0], mk_i(0, 8), 6'd0, 2'd0});
                chk($sformatf("hold_nopop%0d_%0d", dd, k), 64'(pop[dd]), 64'd0);
            end
        end
        chk("hold_count_b2b", 64'(cnt[0]), 64'd12);
        chk("hold_count_nb",  64'(cnt[1]), 64'd12);
        acc = 1'b1;
        repeat (8) step();
        chk("drain_count_b2b", 64'(cnt[0]), 64'd14);
        chk("drain_count_nb",  64'(cnt[1]), 64'd14);

        // Idle with all FIFOs empty, then a single late entry on channel 1.
        for (int k = 0; k < 10; k++) begin
            step();
            for (int dd = 0; dd < 2; dd++) begin
                chk($sformatf("idle%0d_%0d", dd, k), {63'd0, valid[dd]} | 64'(pop[dd]), 64'd0);
            end
        end
        load(1, 64'h7F, 8'd5);
        #1;
        chk("late_pop_b2b", 64'(pop[0]), 64'b0010);
        chk("late_pop_nb",  64'(pop[1]), 64'b0010);
        step();
        for (int dd = 0; dd < 2; dd++) begin
            chk($sformatf("late_word%0d", dd), {data[dd][47:0], index[dd], 7'd0, valid[dd]},
                {48'h7F, 8'd5, 7'd0, 1'b1});
            chk($sformatf("late_ch%0d", dd), 64'(chan[dd]), 64'd1);
        end
        repeat (4) step();
        chk("late_count", 64'(cnt[0]) + 64'(cnt[1]), 64'd30);

        // Reset while a popped word is held: that word is lost, the next entry survives.
        acc = 1'b0;
        load(0, mk_d(0, 10), mk_i(0, 10));
        load(0, mk_d(0, 11), mk_i(0, 11));
        repeat (3) step();
        chk("pre_reset_valid", 64'(valid[0]) + 64'(valid[1]), 64'd2);
        reset = 1'b1;
        #1;
        chk("reset_cycle_nopop", 64'(pop[0]) | 64'(pop[1]), 64'd0);
        step();
        for (int dd = 0; dd < 2; dd++) begin
            chk($sformatf("midreset_out%0d", dd), {data[dd][54:0], index[dd], valid[dd]}, 64'd0);
            chk($sformatf("midreset_ch_cnt%0d", dd), {32'(chan[dd]), cnt[dd]}, 64'd0);
            if (expq[dd].size() != 0) void'(expq[dd].pop_front());
        end
        reset = 1'b0;
        acc   = 1'b1;
        ph[0] = '0; ph[1] = '0;
        for (int k = 1; k <= 6; k++) begin
            step();
            for (int dd = 0; dd < 2; dd++) ph[dd][k-1] = (pop[dd] != '0);
        end
        chk("postreset_pop_b2b", 64'(ph[0]), 64'b000001);
        chk("postreset_pop_nb",  64'(ph[1]), 64'b000001);
        chk("postreset_count", {cnt[0], cnt[1]}, {32'd1, 32'd1});

        chk("scoreboard_empty", 64'(expq[0].size()) + 64'(expq[1].size()), 64'd0);

        checks = checks + mon_checks;
        errors = errors + mon_errors;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
